// File: rtl/fetch_stage.sv
// Dual-issue instruction fetch stage: drives two synchronous memory read ports
// (PC and PC+4), captures the returned pair into a bundle queue and hands the
// bundles to decode through a valid/ready handshake. A redirect flushes all
// older work and restarts fetch at the new PC.
module fetch_stage #(
  parameter logic [31:0] ResetPc = 32'h0000_0000,
  parameter int unsigned Depth   = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr_a,
  output logic [31:0] imem_addr_b,
  input  logic [31:0] imem_data_a,
  input  logic [31:0] imem_data_b,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr_a,
  output logic [31:0] out_instr_b
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [CntW:0] DepthW = (CntW + 1)'(Depth);

  logic [31:0]     r_pc_req;
  logic            r_inflight;
  logic [31:0]     r_inflight_pc;
  logic [31:0]     r_q_pc    [Depth];
  logic [31:0]     r_q_a     [Depth];
  logic [31:0]     r_q_b     [Depth];
  logic [PtrW-1:0] r_rd_ptr;
  logic [PtrW-1:0] r_wr_ptr;
  logic [CntW-1:0] r_count;

  logic [CntW:0]   w_occupancy;
  logic            w_req_fire;
  logic            w_push;
  logic            w_pop;
  logic [31:0]     w_redirect_pc;

  // Queue entries plus the outstanding request act as credits; a request only
  // issues when a slot is guaranteed for its response, so pushes never overflow.
  // A pop in the same cycle is deliberately not counted as freeing a slot.
  assign w_occupancy   = {1'b0, r_count} + {{CntW{1'b0}}, r_inflight};
  assign w_req_fire    = !redirect_valid && (w_occupancy < DepthW);
  assign w_push        = r_inflight && !redirect_valid;
  assign w_pop         = out_valid && out_ready;
  assign w_redirect_pc = redirect_pc & 32'hFFFF_FFFC;

  assign imem_addr_a = r_pc_req;
  assign imem_addr_b = r_pc_req + 32'd4;

  assign out_valid   = (r_count != '0) && !redirect_valid;
  assign out_pc      = r_q_pc[r_rd_ptr];
  assign out_instr_a = r_q_a[r_rd_ptr];
  assign out_instr_b = r_q_b[r_rd_ptr];

  // Fetch PC generation and tracking of the single outstanding memory request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc_req      <= ResetPc;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else if (redirect_valid) begin
      r_pc_req   <= w_redirect_pc;
      r_inflight <= 1'b0;
    end else if (w_req_fire) begin
      r_pc_req      <= r_pc_req + 32'd8;
      r_inflight    <= 1'b1;
      r_inflight_pc <= r_pc_req;
    end else begin
      r_inflight <= 1'b0;
    end
  end

  // Queue pointers and occupancy; redirect empties the queue and blocks any pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (redirect_valid) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CntW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CntW'(1);
      end
    end
  end

  // Bundle storage: captures the memory response for the outstanding request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        r_q_pc[i] <= '0;
        r_q_a[i]  <= '0;
        r_q_b[i]  <= '0;
      end
    end else if (w_push) begin
      r_q_pc[r_wr_ptr] <= r_inflight_pc;
      r_q_a[r_wr_ptr]  <= imem_data_a;
      r_q_b[r_wr_ptr]  <= imem_data_b;
    end
  end

endmodule
